// File: rtl/regfile_banked.sv
// Banked ARM register file: three combinational read ports, ALU and load write ports
// with same-cycle bypass, and a per-register load-pending scoreboard for the hazard unit.
module regfile_banked #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3,
  output logic              busy1,
  output logic              busy2,
  output logic              busy3,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              wel,
  input  logic [ADDR_W-1:0] wal,
  input  logic [DATA_W-1:0] wdl,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_dst,
  input  logic [DATA_W-1:0] r15,
  output logic              conflict_err,
  output logic [ADDR_W:0]   ld_outstanding
);

  localparam int NST = NREG - 1;
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREG - 1);

  logic [DATA_W-1:0] r_regs [NST];
  logic [NST-1:0]    r_pend;
  logic              r_conflict;
  logic [ADDR_W:0]   r_ld_cnt;

  logic [NST-1:0]    w_pend_nxt;
  logic              w_conflict;
  logic [ADDR_W-1:0] w_ra   [3];
  logic [DATA_W-1:0] w_rd   [3];
  logic [2:0]        w_busy;

  function automatic logic [ADDR_W:0] popcount(input logic [NST-1:0] bits);
    logic [ADDR_W:0] cnt;
    cnt = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < NST; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, bits[i]};
    end
    return cnt;
  endfunction

  assign w_ra[0] = ra1;
  assign w_ra[1] = ra2;
  assign w_ra[2] = ra3;

  // Read mux: PC first, then load bypass, then ALU bypass, then storage
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      w_rd[p]   = {DATA_W{1'b0}};
      w_busy[p] = 1'b0;
      if (w_ra[p] == PC_IDX) begin
        w_rd[p]   = r15;
        w_busy[p] = 1'b0;
      end else if (wel && (wal == w_ra[p])) begin
        w_rd[p]   = wdl;
        w_busy[p] = 1'b0;
      end else if (we3 && (wa3 == w_ra[p])) begin
        w_rd[p]   = wd3;
        w_busy[p] = r_pend[w_ra[p]];
      end else begin
        w_rd[p]   = r_regs[w_ra[p]];
        w_busy[p] = r_pend[w_ra[p]];
      end
    end
  end

  assign rd1   = w_rd[0];
  assign rd2   = w_rd[1];
  assign rd3   = w_rd[2];
  assign busy1 = w_busy[0];
  assign busy2 = w_busy[1];
  assign busy3 = w_busy[2];

  // Scoreboard next state: an issue to the same register outranks its retirement
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < NST; i++) begin
      if (ld_issue && (ld_dst == ADDR_W'(i))) begin
        w_pend_nxt[i] = 1'b1;
      end else if (wel && (wal == ADDR_W'(i))) begin
        w_pend_nxt[i] = 1'b0;
      end else begin
        w_pend_nxt[i] = r_pend[i];
      end
    end
  end

  assign w_conflict = we3 && wel && (wa3 == wal) && (wa3 != PC_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NST; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NST; i++) begin
        if (wel && (wal == ADDR_W'(i))) begin
          r_regs[i] <= wdl;
        end else if (we3 && (wa3 == ADDR_W'(i))) begin
          r_regs[i] <= wd3;
        end else begin
          r_regs[i] <= r_regs[i];
        end
      end
    end
  end

  // Count is recomputed from the bits each edge so it can never drift or wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= {NST{1'b0}};
      r_conflict <= 1'b0;
      r_ld_cnt   <= {(ADDR_W+1){1'b0}};
    end else begin
      r_pend     <= w_pend_nxt;
      r_conflict <= w_conflict;
      r_ld_cnt   <= popcount(w_pend_nxt);
    end
  end

  assign conflict_err   = r_conflict;
  assign ld_outstanding = r_ld_cnt;

endmodule

// File: tb/tb_regfile_banked.sv
// Directed and randomized bench for regfile_banked against an array-based reference model.
module tb_regfile_banked;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ra1, ra2, ra3, wa3, wal, ld_dst;
  logic [31:0] rd1, rd2, rd3, wd3, wdl, r15;
  logic        busy1, busy2, busy3, we3, wel, ld_issue, conflict_err;
  logic [4:0]  ld_outstanding;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_regs [16];
  bit          m_pend [16];
  logic        m_conf;
  int          m_cnt;

  always #5 clk = ~clk;

  regfile_banked dut (
    .clk(clk), .rst_n(rst_n),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .busy1(busy1), .busy2(busy2), .busy3(busy3),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .wel(wel), .wal(wal), .wdl(wdl),
    .ld_issue(ld_issue), .ld_dst(ld_dst),
    .r15(r15),
    .conflict_err(conflict_err), .ld_outstanding(ld_outstanding)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a == 4'd15) return r15;
    if (wel && wal == a) return wdl;
    if (we3 && wa3 == a) return wd3;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    if (a == 4'd15) return 1'b0;
    if (wel && wal == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
    m_conf = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic idle();
    we3 = 1'b0; wel = 1'b0; ld_issue = 1'b0;
    wa3 = 4'd0; wal = 4'd0; ld_dst = 4'd0;
    wd3 = 32'd0; wdl = 32'd0;
  endtask

  task automatic settle_check();
    #1;
    check("rd1", rd1, exp_rd(ra1));
    check("rd2", rd2, exp_rd(ra2));
    check("rd3", rd3, exp_rd(ra3));
    check("busy1", busy1, exp_busy(ra1));
    check("busy2", busy2, exp_busy(ra2));
    check("busy3", busy3, exp_busy(ra3));
  endtask

  // Advance one rising edge, apply the architectural update rules, then check registered outputs
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      m_conf = we3 && wel && (wa3 == wal) && (wa3 != 4'd15);
      if (wel && wal != 4'd15) begin
        m_regs[wal] = wdl;
        m_pend[wal] = 1'b0;
      end
      if (we3 && wa3 != 4'd15 && !(wel && wal == wa3)) m_regs[wa3] = wd3;
      if (ld_issue && ld_dst != 4'd15) m_pend[ld_dst] = 1'b1;
      m_cnt = 0;
      for (int i = 0; i < 16; i++) m_cnt += int'(m_pend[i]);
    end
    #1;
    check("conflict_err", conflict_err, m_conf);
    check("ld_outstanding", ld_outstanding, 64'(m_cnt));
  endtask

  initial begin
    idle();
    ra1 = 4'd0; ra2 = 4'd0; ra3 = 4'd0;
    r15 = 32'h0000_1008;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int a = 0; a < 16; a++) begin
      ra1 = 4'(a); ra2 = 4'(a); ra3 = 4'(15 - a);
      #1;
      check("reset_rd1", rd1, (a == 15) ? 32'h0000_1008 : 32'd0);
      check("reset_rd3", rd3, (a == 0) ? 32'h0000_1008 : 32'd0);
      check("reset_busy1", busy1, 1'b0);
      check("reset_busy2", busy2, 1'b0);
    end
    check("reset_ld_outstanding", ld_outstanding, 5'd0);
    check("reset_conflict", conflict_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // ALU write with same-cycle bypass, then hold, then ignored PC write
    we3 = 1'b1; wa3 = 4'd5; wd3 = 32'hDEAD_BEEF; ra1 = 4'd5;
    settle_check();
    check("alu_bypass", rd1, 32'hDEAD_BEEF);
    tick();
    @(negedge clk) idle(); ra1 = 4'd5;
    settle_check();
    check("alu_hold", rd1, 32'hDEAD_BEEF);
    tick();
    @(negedge clk) we3 = 1'b1; wa3 = 4'd15; wd3 = 32'h1234_5678; ra1 = 4'd15;
    settle_check();
    check("pc_write_bypass", rd1, 32'h0000_1008);
    tick();
    @(negedge clk) idle(); ra1 = 4'd15;
    settle_check();
    check("pc_write_ignored", rd1, 32'h0000_1008);
    we3 = 1'b1; wa3 = 4'd9; wd3 = 32'h0000_CAFE;
    tick();

    // Both ports to r3: load data wins, conflict pulses once
    @(negedge clk) idle();
    we3 = 1'b1; wa3 = 4'd3; wd3 = 32'h11; wel = 1'b1; wal = 4'd3; wdl = 32'h22; ra2 = 4'd3;
    settle_check();
    check("conflict_bypass", rd2, 32'h22);
    tick();
    check("conflict_pulse", conflict_err, 1'b1);
    @(negedge clk) idle(); ra2 = 4'd3;
    settle_check();
    check("conflict_stored", rd2, 32'h22);
    tick();
    check("conflict_cleared", conflict_err, 1'b0);

    // Load to r7: pending, then retire with bypass
    @(negedge clk) idle(); ld_issue = 1'b1; ld_dst = 4'd7;
    tick();
    check("ld7_count", ld_outstanding, 5'd1);
    @(negedge clk) idle(); ra3 = 4'd7;
    settle_check();
    check("ld7_busy", busy3, 1'b1);
    tick();
    @(negedge clk) idle();
    tick();
    @(negedge clk) wel = 1'b1; wal = 4'd7; wdl = 32'h55;
    settle_check();
    check("ld7_retire_busy", busy3, 1'b0);
    check("ld7_retire_data", rd3, 32'h55);
    tick();
    check("ld7_count_zero", ld_outstanding, 5'd0);

    // Issue and retire to the same register in one cycle: set wins
    @(negedge clk) idle(); ld_issue = 1'b1; ld_dst = 4'd4;
    tick();
    @(negedge clk) ld_issue = 1'b1; ld_dst = 4'd4; wel = 1'b1; wal = 4'd4; wdl = 32'h44; ra1 = 4'd4;
    settle_check();
    tick();
    check("b2b_count", ld_outstanding, 5'd1);
    @(negedge clk) idle(); ra1 = 4'd4;
    settle_check();
    check("b2b_busy", busy1, 1'b1);
    for (int r = 1; r <= 3; r++) begin
      ld_issue = 1'b1; ld_dst = 4'(r);
      tick();
      @(negedge clk) idle();
    end
    check("four_pending", ld_outstanding, 5'd4);

    // Asynchronous reset mid-cycle with loads pending
    ra1 = 4'd9; ra2 = 4'd4; ra3 = 4'd15;
    settle_check();
    check("r9_before_reset", rd1, 32'h0000_CAFE);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_r9", rd1, 32'd0);
    check("async_busy2", busy2, 1'b0);
    check("async_pc", rd3, 32'h0000_1008);
    check("async_count", ld_outstanding, 5'd0);
    settle_check();
    tick();
    @(negedge clk) rst_n = 1'b1;

    // Randomized traffic with clustered addresses to provoke collisions
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      we3 = 1'($urandom_range(0, 1));
      wel = 1'($urandom_range(0, 1));
      ld_issue = 1'($urandom_range(0, 1));
      wa3 = 4'($urandom_range(0, 15));
      wal = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom_range(0, 15));
      ld_dst = ($urandom_range(0, 3) == 0) ? wal : 4'($urandom_range(0, 15));
      wd3 = $urandom; wdl = $urandom; r15 = $urandom;
      ra1 = ($urandom_range(0, 2) == 0) ? wal : 4'($urandom_range(0, 15));
      ra2 = ($urandom_range(0, 2) == 0) ? wa3 : 4'($urandom_range(0, 15));
      ra3 = 4'($urandom_range(0, 15));
      settle_check();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
